mc14500_sequencer: RTL and testbench
====================================

MC14500_SEQUENCER -- requirements
Module: mc14500_sequencer

Interface
REQ-001 Parameter STACK_DEPTH, default 4, return-stack entries (2..8).
REQ-002 Parameter RESET_VECTOR, default 7'h00, PC value after reset and after stack-underflow restart.
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 run  input  1  enable; 0 stalls the sequencer in place.
REQ-006 rom_addr  output  7  program counter, drives ROM address.
REQ-007 rom_data  input  8  combinational ROM data for rom_addr, same cycle.
REQ-008 icu_ce  output  1  strobe: rom_data is an instruction the ICU executes this cycle.
REQ-009 jmp_i, rtn_i, flg0_i, flgf_i  input  1 each  ICU flag outputs, valid only in cycles with icu_ce=1.
REQ-010 resume_i  input  1  single-cycle pulse releasing HALT.
REQ-011 halted  output  1  high while in HALT.
REQ-012 stack_err  output  1  sticky: overflow or underflow occurred.
REQ-013 flg0_cnt  output  8  count of flg0_i pulses accepted.

Function
REQ-014 States: FETCH, TARGET, HALT; reset enters FETCH.
REQ-015 run=0 in any state: no state, PC, stack or counter change; icu_ce=0.
REQ-016 FETCH, run=1: icu_ce=1; flags evaluated with priority jmp_i > rtn_i > flgf_i.
REQ-017 FETCH, jmp_i=1: PC <= PC+1; next state TARGET.
REQ-018 FETCH, rtn_i=1 (no jmp): stack non-empty -> PC <= top, pop; empty -> PC <= RESET_VECTOR, stack_err <= 1.
REQ-019 FETCH, flgf_i=1 (no jmp/rtn): PC <= PC+1; next state HALT.
REQ-020 FETCH, no flag: PC <= PC+1; stay FETCH.
REQ-021 PC arithmetic is 7-bit modulo: 7'h7F+1 -> 7'h00, no error.
REQ-022 TARGET: icu_ce=0; rom_data is jump-target byte; PC <= rom_data[6:0]; next state FETCH.
REQ-023 TARGET with rom_data[7]=1 (call): push PC+1 (modulo 128) before load; stack full -> no push, no jump, PC <= PC+1, stack_err <= 1.
REQ-024 flg0_i=1 with icu_ce=1 increments flg0_cnt, wrapping 8'hFF -> 8'h00; independent of other flags.
REQ-025 HALT: icu_ce=0, halted=1, PC held; resume_i=1 with run=1 -> FETCH next cycle; resume_i while run=0 is ignored.
REQ-026 Flags and resume_i ignored whenever icu_ce=0 or not in the state that consumes them.
REQ-027 Stack is LIFO, depth STACK_DEPTH, contents undefined after reset, pointer cleared.
REQ-028 Outputs are registered-state-derived; no combinational path from rom_data to rom_addr.

Reset
REQ-029 rst_n=0 asynchronously forces: state FETCH, rom_addr=RESET_VECTOR, stack empty, stack_err=0, flg0_cnt=0, halted=0; icu_ce=0 while rst_n=0.
REQ-030 Reset asserted mid-TARGET or mid-HALT aborts the operation; no push occurs.
REQ-031 First rising edge after rst_n deassert with run=1 executes the instruction at RESET_VECTOR.

Verification
REQ-032 Linear run: reset, run=1, no flags for 130 cycles -> rom_addr 0,1,...,127,0,1; icu_ce=1 every cycle.
REQ-033 Jump: jmp_i at PC=5, ROM[6]=8'h20 -> rom_addr 5,6,32; icu_ce 1,0,1; stack unchanged.
REQ-034 Call/return: jmp_i at PC=3, ROM[4]=8'hA0, rtn_i at PC=32 -> rom_addr 3,4,32,5; stack depth 1 then 0.
REQ-035 Stack errors: five nested calls with STACK_DEPTH=4 -> fifth call falls through (PC+1), stack_err=1; rtn_i on empty stack -> rom_addr=RESET_VECTOR, stack_err stays 1.
REQ-036 Halt/stall: flgf_i at PC=10 -> halted=1, rom_addr=11 held; run=0 then resume_i ignored; run=1 + resume_i -> FETCH at 11; simultaneous jmp_i+flgf_i -> jump taken, no halt.
REQ-037 Async reset: rst_n low mid-TARGET, between clock edges -> rom_addr=RESET_VECTOR, flg0_cnt=0, stack_err=0 immediately, without a clock edge.

Source files
------------

// File: rtl/mc14500_sequencer.sv
// Program sequencer for an MC14500-style ICU: PC, jump/call target fetch,
// return stack, halt/resume handshake and flg0 event counter.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_FETCH  | rom_data is an instruction; ICU flags steer the PC
//   S_TARGET | rom_data is a jump-target byte; bit 7 marks a call
//   S_HALT   | PC held, waiting for resume_i
module mc14500_sequencer #(
   parameter int unsigned STACK_DEPTH  = 4,
   parameter logic [6:0]  RESET_VECTOR = 7'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   output logic [6:0] rom_addr,
   input  logic [7:0] rom_data,
   output logic       icu_ce,
   input  logic       jmp_i,
   input  logic       rtn_i,
   input  logic       flg0_i,
   input  logic       flgf_i,
   input  logic       resume_i,
   output logic       halted,
   output logic       stack_err,
   output logic [7:0] flg0_cnt
);

   localparam int SPW   = $clog2(STACK_DEPTH + 1);
   localparam int SLOTS = 1 << SPW;

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_TARGET = 2'd1,
      S_HALT   = 2'd2
   } state_t;

   state_t           r_state;
   logic [6:0]       r_pc;
   logic [SPW-1:0]   r_sp;
   logic [6:0]       r_stack [0:SLOTS-1];
   logic             r_stack_err;
   logic [7:0]       r_flg0_cnt;

   logic [6:0]       w_pc_inc;
   logic [SPW-1:0]   w_sp_dec;
   logic             w_full;
   logic             w_empty;
   logic             w_push;

   assign w_pc_inc = r_pc + 7'd1;
   assign w_sp_dec = r_sp - SPW'(1);
   assign w_full   = (r_sp == SPW'(STACK_DEPTH));
   assign w_empty  = (r_sp == '0);
   assign w_push   = run && (r_state == S_TARGET) && rom_data[7] && !w_full;

   // rst_n gates the strobe so the ICU never executes while reset is held
   assign icu_ce    = rst_n && run && (r_state == S_FETCH);
   assign rom_addr  = r_pc;
   assign halted    = (r_state == S_HALT);
   assign stack_err = r_stack_err;
   assign flg0_cnt  = r_flg0_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_FETCH;
         r_pc        <= RESET_VECTOR;
         r_sp        <= '0;
         r_stack_err <= 1'b0;
         r_flg0_cnt  <= 8'd0;
      end else if (run) begin
         case (r_state)
            S_FETCH: begin
               if (flg0_i)
                  r_flg0_cnt <= r_flg0_cnt + 8'd1;
               if (jmp_i) begin
                  r_pc    <= w_pc_inc;
                  r_state <= S_TARGET;
               end else if (rtn_i) begin
                  if (!w_empty) begin
                     r_pc <= r_stack[w_sp_dec];
                     r_sp <= w_sp_dec;
                  end else begin
                     r_pc        <= RESET_VECTOR;
                     r_stack_err <= 1'b1;
                  end
               end else if (flgf_i) begin
                  r_pc    <= w_pc_inc;
                  r_state <= S_HALT;
               end else begin
                  r_pc <= w_pc_inc;
               end
            end
            S_TARGET: begin
               r_state <= S_FETCH;
               // a call with no room falls through past the target byte
               if (rom_data[7] && w_full) begin
                  r_pc        <= w_pc_inc;
                  r_stack_err <= 1'b1;
               end else begin
                  r_pc <= rom_data[6:0];
                  if (rom_data[7])
                     r_sp <= r_sp + SPW'(1);
               end
            end
            S_HALT: begin
               if (resume_i)
                  r_state <= S_FETCH;
            end
            default: r_state <= S_FETCH;
         endcase
      end
   end

   // stack storage carries no reset; validity is tracked by r_sp alone
   always_ff @(posedge clk) begin
      if (w_push)
         r_stack[r_sp] <= w_pc_inc;
   end

endmodule

// File: tb/tb_mc14500_sequencer.sv
// Bench for mc14500_sequencer: directed flag sequences against a queue-based
// behavioural model, compared every cycle, plus hand-computed literal checks.
module tb_mc14500_sequencer;

   localparam int DEPTH    = 4;
   localparam int RV       = 0;
   localparam int M_FETCH  = 0;
   localparam int M_TARGET = 1;
   localparam int M_HALT   = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       run = 1'b0;
   logic       jmp_i = 1'b0;
   logic       rtn_i = 1'b0;
   logic       flg0_i = 1'b0;
   logic       flgf_i = 1'b0;
   logic       resume_i = 1'b0;
   logic [6:0] rom_addr;
   logic [7:0] rom_data;
   logic       icu_ce;
   logic       halted;
   logic       stack_err;
   logic [7:0] flg0_cnt;

   logic [7:0] rom [0:127];

   int errors = 0;
   int checks = 0;
   bit chk_on = 1'b0;

   int m_pc;
   int m_mode;
   int m_err;
   int m_cnt;
   int m_byte;
   int m_stk[$];

   always #5 clk = ~clk;

   assign rom_data = rom[rom_addr];

   mc14500_sequencer #(
      .STACK_DEPTH (DEPTH),
      .RESET_VECTOR(7'h00)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .icu_ce   (icu_ce),
      .jmp_i    (jmp_i),
      .rtn_i    (rtn_i),
      .flg0_i   (flg0_i),
      .flgf_i   (flgf_i),
      .resume_i (resume_i),
      .halted   (halted),
      .stack_err(stack_err),
      .flg0_cnt (flg0_cnt)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc   = RV;
      m_mode = M_FETCH;
      m_err  = 0;
      m_cnt  = 0;
      m_stk.delete();
   endtask

   // one rising edge of the sequencer as described by its rules
   task automatic model_step();
      if (!run) return;
      case (m_mode)
         M_FETCH: begin
            if (flg0_i) m_cnt = (m_cnt + 1) % 256;
            if (jmp_i) begin
               m_pc   = (m_pc + 1) % 128;
               m_mode = M_TARGET;
            end else if (rtn_i) begin
               if (m_stk.size() > 0) m_pc = m_stk.pop_back();
               else begin
                  m_pc  = RV;
                  m_err = 1;
               end
            end else begin
               m_pc = (m_pc + 1) % 128;
               if (flgf_i) m_mode = M_HALT;
            end
         end
         M_TARGET: begin
            m_byte = int'(rom[m_pc]);
            m_mode = M_FETCH;
            if (m_byte >= 128 && m_stk.size() == DEPTH) begin
               m_err = 1;
               m_pc  = (m_pc + 1) % 128;
            end else begin
               if (m_byte >= 128) m_stk.push_back((m_pc + 1) % 128);
               m_pc = m_byte % 128;
            end
         end
         default: begin
            if (resume_i) m_mode = M_FETCH;
         end
      endcase
   endtask

   // inputs change 2 time units after the rising edge; model follows the edge
   task automatic step(input bit r, input bit j, input bit t, input bit f,
                       input bit z, input bit s);
      run = r; jmp_i = j; rtn_i = t; flgf_i = f; flg0_i = z; resume_i = s;
      @(posedge clk);
      if (rst_n) model_step();
      #2;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      run = 0; jmp_i = 0; rtn_i = 0; flgf_i = 0; flg0_i = 0; resume_i = 0;
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   always begin
      @(negedge clk);
      if (chk_on) begin
         chk("cyc rom_addr", int'(rom_addr), m_pc);
         chk("cyc icu_ce", int'(icu_ce), (rst_n && run && m_mode == M_FETCH) ? 1 : 0);
         chk("cyc halted", int'(halted), (m_mode == M_HALT) ? 1 : 0);
         chk("cyc stack_err", int'(stack_err), m_err);
         chk("cyc flg0_cnt", int'(flg0_cnt), m_cnt);
      end
   end

   initial begin
      for (int i = 0; i < 128; i++) rom[i] = 8'h00;
      rom[4]  = 8'hA0;
      rom[6]  = 8'h20;
      rom[41] = 8'hB2;
      rom[51] = 8'hBC;
      rom[61] = 8'hC6;
      rom[71] = 8'hD0;
      rom[81] = 8'hDA;

      #1;
      rst_n = 1'b0;
      model_reset();
      chk_on = 1'b1;
      #1;
      chk("rst rom_addr", int'(rom_addr), 0);
      chk("rst icu_ce", int'(icu_ce), 0);
      chk("rst halted", int'(halted), 0);
      chk("rst stack_err", int'(stack_err), 0);
      chk("rst flg0_cnt", int'(flg0_cnt), 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // linear run with PC wrap
      idle(130);
      chk("linear end addr", int'(rom_addr), 2);
      chk("linear icu_ce", int'(icu_ce), 1);

      // plain jump; flags offered in TARGET must be ignored
      do_reset();
      idle(5);
      chk("jmp at pc", int'(rom_addr), 5);
      step(1, 1, 0, 0, 0, 0);
      chk("jmp target addr", int'(rom_addr), 6);
      chk("jmp target ce", int'(icu_ce), 0);
      step(1, 1, 1, 1, 1, 1);
      chk("jmp dest", int'(rom_addr), 32);
      chk("jmp flg0 ignored", int'(flg0_cnt), 0);

      // call then return
      do_reset();
      idle(3);
      step(1, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      chk("call dest", int'(rom_addr), 32);
      step(1, 0, 1, 0, 0, 0);
      chk("return addr", int'(rom_addr), 5);
      chk("return no err", int'(stack_err), 0);

      // nested calls overflow, then unwind to underflow
      do_reset();
      idle(40);
      repeat (4) begin
         step(1, 1, 0, 0, 0, 0);
         step(1, 0, 0, 0, 0, 0);
      end
      chk("nest 4th dest", int'(rom_addr), 80);
      chk("nest no err yet", int'(stack_err), 0);
      step(1, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      chk("overflow fallthru", int'(rom_addr), 82);
      chk("overflow err", int'(stack_err), 1);
      step(1, 0, 1, 0, 0, 0);
      chk("pop1", int'(rom_addr), 72);
      repeat (3) step(1, 0, 1, 0, 0, 0);
      chk("pop4", int'(rom_addr), 42);
      step(1, 0, 1, 0, 0, 0);
      chk("underflow addr", int'(rom_addr), RV);
      chk("underflow err", int'(stack_err), 1);

      // halt, stall, resume, jmp+flgf priority, stall in TARGET
      do_reset();
      idle(10);
      step(1, 0, 0, 1, 0, 0);
      chk("halt addr", int'(rom_addr), 11);
      chk("halt flag", int'(halted), 1);
      idle(3);
      step(0, 0, 0, 0, 0, 1);
      chk("resume w/o run", int'(halted), 1);
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 1);
      chk("resumed", int'(halted), 0);
      chk("resumed addr", int'(rom_addr), 11);
      chk("resumed ce", int'(icu_ce), 1);
      step(0, 1, 0, 0, 1, 0);
      chk("stall fetch", int'(rom_addr), 11);
      step(1, 1, 0, 1, 0, 0);
      chk("jmp beats flgf", int'(halted), 0);
      chk("jmp beats flgf addr", int'(rom_addr), 12);
      step(0, 0, 0, 0, 0, 0);
      chk("stall target", int'(rom_addr), 12);
      step(1, 0, 0, 0, 0, 0);
      chk("target rom 0", int'(rom_addr), 0);

      // flg0 counter wrap and stall
      do_reset();
      repeat (255) step(1, 0, 0, 0, 1, 0);
      chk("flg0 255", int'(flg0_cnt), 255);
      repeat (3) step(1, 0, 0, 0, 1, 0);
      chk("flg0 wrap", int'(flg0_cnt), 2);
      repeat (2) step(0, 0, 0, 0, 1, 0);
      chk("flg0 stalled", int'(flg0_cnt), 2);

      // async reset between edges while in TARGET
      do_reset();
      step(1, 0, 1, 0, 0, 0);
      chk("pre err", int'(stack_err), 1);
      idle(5);
      step(1, 1, 0, 0, 1, 0);
      chk("pre target", int'(rom_addr), 6);
      chk("pre cnt", int'(flg0_cnt), 1);
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async addr", int'(rom_addr), RV);
      chk("async cnt", int'(flg0_cnt), 0);
      chk("async err", int'(stack_err), 0);
      chk("async ce", int'(icu_ce), 0);
      chk("async halted", int'(halted), 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      step(1, 0, 0, 0, 0, 0);
      chk("first edge", int'(rom_addr), 1);
      step(1, 0, 1, 0, 0, 0);
      chk("no push kept", int'(rom_addr), RV);
      chk("no push err", int'(stack_err), 1);

      @(negedge clk);
      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
